// File: rtl/dump_scheduler.sv
// dump_scheduler: walks the masked capture channels in ascending order. For each
// channel it reads every sample oldest-first through the shared RAM port and sends
// each byte to the UART transmitter.
// Latency: a request accepted at edge 0 gives SELECT in cycle 1, ram_en in cycle 2
// and tx_start in cycle 4. tx_done at edge k gives ram_en in k+1 and tx_start in k+3.
// Backpressure: exactly one byte is in flight at a time, and the next RAM read waits
// for tx_done. dump_req is ignored while busy. abort returns to IDLE at the next edge.
// Optional header: define DUMP_HDR_EN to send {4'hA, channel} ahead of each channel.
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   dump_req, ch_mask,          dump command; ch_mask and start_addr are
//   start_addr, capture_done    sampled together with dump_req
//   abort                       drop the dump in progress
//   ram_en/ram_addr/ram_ch_sel  shared RAM read port (1-cycle read latency)
//   ram_rdata                   all channels' read data; channel i in [i*DATA_W +: DATA_W]
//   tx_data/tx_start/tx_done    UART byte handshake
//   busy, dump_finished,        status outputs
//   clr_capture_done, reject
module dump_scheduler #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        dump_req,
  input  logic [NUM_CH-1:0]                           ch_mask,
  input  logic                                        capture_done,
  input  logic [ADDR_W-1:0]                           start_addr,
  input  logic                                        abort,
  output logic                                        ram_en,
  output logic [ADDR_W-1:0]                           ram_addr,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ram_ch_sel,
  input  logic [NUM_CH*DATA_W-1:0]                    ram_rdata,
  output logic [DATA_W-1:0]                           tx_data,
  output logic                                        tx_start,
  input  logic                                        tx_done,
  output logic                                        busy,
  output logic                                        dump_finished,
  output logic                                        clr_capture_done,
  output logic                                        reject
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE, SELECT, READ, WAIT_RD, SEND, WAIT_TX, DONE, HDR, WAIT_HDR
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] mask_q;   // channels still to be dumped
  logic [ADDR_W-1:0] start_q;
  logic [CNT_W-1:0]  cnt;      // samples already sent on the current channel
  logic [CH_W-1:0]   low_idx;  // lowest channel still pending
  logic [DATA_W-1:0] rd_byte;  // read data lane of the selected channel

  // Scan from the top down, so the last assignment made is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = CH_W'(i);
    end
  end

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ram_ch_sel == CH_W'(i)) rd_byte = ram_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      mask_q           <= '0;
      start_q          <= '0;
      cnt              <= '0;
      ram_en           <= 1'b0;
      ram_addr         <= '0;
      ram_ch_sel       <= '0;
      tx_data          <= '0;
      tx_start         <= 1'b0;
      busy             <= 1'b0;
      dump_finished    <= 1'b0;
      clr_capture_done <= 1'b0;
      reject           <= 1'b0;
    end else begin
      // Strobes default low. Each state that needs one raises it for one cycle.
      ram_en           <= 1'b0;
      tx_start         <= 1'b0;
      dump_finished    <= 1'b0;
      clr_capture_done <= 1'b0;
      reject           <= 1'b0;
      if (abort && state != IDLE) begin
        // abort is checked before the case statement, so it wins over a
        // tx_done arriving in the same cycle.
        state  <= IDLE;
        busy   <= 1'b0;
        mask_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (dump_req) begin
              if (capture_done && (ch_mask != '0)) begin
                mask_q  <= ch_mask;
                start_q <= start_addr;
                busy    <= 1'b1;
                state   <= SELECT;
              end else begin
                reject <= 1'b1;
              end
            end
          end
          SELECT: begin
            if (mask_q == '0) begin
              dump_finished    <= 1'b1;
              clr_capture_done <= 1'b1;
              state            <= DONE;
            end else begin
              ram_ch_sel <= low_idx;
              ram_addr   <= start_q;
              cnt        <= '0;
`ifdef DUMP_HDR_EN
              tx_data  <= {4'hA, (DATA_W-4)'(low_idx)};
              tx_start <= 1'b1;
              state    <= HDR;
`else
              ram_en <= 1'b1;
              state  <= READ;
`endif
            end
          end
          READ:    state <= WAIT_RD;
          WAIT_RD: begin
            tx_data  <= rd_byte;
            tx_start <= 1'b1;
            state    <= SEND;
          end
          SEND:    state <= WAIT_TX;
          WAIT_TX: begin
            if (tx_done) begin
              ram_addr <= ram_addr + 1'b1;  // wraps modulo DEPTH
              cnt      <= cnt + 1'b1;
              if (cnt == CNT_W'(DEPTH - 1)) begin
                mask_q[ram_ch_sel] <= 1'b0;
                state              <= SELECT;
              end else begin
                ram_en <= 1'b1;
                state  <= READ;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          HDR:      state <= WAIT_HDR;
          WAIT_HDR: begin
            if (tx_done) begin
              ram_en <= 1'b1;
              state  <= READ;
            end
          end
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dump_scheduler.md
Name: dump_scheduler

Overview:
Sequences the read-out of captured waveform RAMs to the UART transmitter after a capture completes. Walks each channel selected in a channel mask, in ascending channel order. For each channel it reads all DEPTH samples oldest-first through a shared RAM read port, then hands each byte to the transmitter with a start/done handshake. Sits between the command processor (dump request and mask), the per-channel capture RAMs and the UART tx.

Parameters:
NUM_CH, 3, number of capture channels (1..8)
ADDR_W, 9, RAM address width; DEPTH = 2^ADDR_W samples per channel
DATA_W, 8, sample width, equal to the UART byte width

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
dump_req  input  1  single-cycle request to start a dump
ch_mask  input  NUM_CH  channels to dump; sampled with dump_req
capture_done  input  1  level; high when RAM contents are valid
start_addr  input  ADDR_W  address of the oldest sample; sampled with dump_req
abort  input  1  synchronous abort of the dump in progress
ram_en  output  1  RAM read enable
ram_addr  output  ADDR_W  RAM read address
ram_ch_sel  output  max(1,$clog2(NUM_CH))  channel whose RAM is being read
ram_rdata  input  NUM_CH*DATA_W  flattened read data; channel i occupies bits [i*DATA_W +: DATA_W]
tx_data  output  DATA_W  byte to transmit
tx_start  output  1  one-cycle transmit strobe
tx_done  input  1  one-cycle pulse when the transmitter finishes a byte
busy  output  1  dump in progress
dump_finished  output  1  one-cycle pulse at normal completion
clr_capture_done  output  1  one-cycle pulse at normal completion
reject  output  1  one-cycle pulse when a dump_req is refused

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0. Latched mask, address, counter and channel index all 0.
- RAM read latency is 1 cycle. Data for the address presented with ram_en in cycle n is valid in cycle n+1.
- State machine: IDLE, SELECT, READ, WAIT_RD, SEND, WAIT_TX, DONE.
- IDLE, dump_req=1, capture_done=1, ch_mask!=0:
  - latch ch_mask and start_addr; go to SELECT.
  - busy rises in the next cycle and stays high through DONE.
- IDLE, dump_req=1 with capture_done=0 or ch_mask=0: reject pulses in the next cycle; stay in IDLE.
- dump_req while busy: ignored; no reject.
- SELECT:
  - if the latched mask is 0, go to DONE.
  - else set ram_ch_sel to the index of the lowest set bit, ram_addr=start_addr, sample counter=0, and go to READ.
- READ: ram_en=1 for exactly one cycle; go to WAIT_RD.
- WAIT_RD: register ram_rdata[ch] into tx_data; go to SEND.
- SEND: tx_start=1 for one cycle; go to WAIT_TX. tx_data is held stable until the next SEND.
- WAIT_TX: wait for tx_done. When it arrives:
  - ram_addr increments modulo DEPTH (0x1FF wraps to 0x000 for ADDR_W=9); counter increments.
  - if counter reaches DEPTH, clear the current bit in the latched mask and go to SELECT; else go to READ.
- tx_done outside WAIT_TX is ignored.
- DONE: dump_finished=1 and clr_capture_done=1 for one cycle, then IDLE. busy falls the cycle after DONE.
- Timing, first byte: dump_req sampled at edge 0 gives SELECT in cycle 1, ram_en in cycle 2, tx_start in cycle 4.
- Timing, subsequent bytes: tx_done sampled at edge k gives ram_en in cycle k+1 and tx_start in cycle k+3.
- abort (any non-IDLE state): go to IDLE at the next edge.
  - busy, ram_en and tx_start are low from that cycle.
  - no dump_finished, no clr_capture_done.
  - the latched mask is cleared.
  - abort has priority over tx_done in the same cycle.
- ch_mask, start_addr and capture_done changes while busy have no effect.

Optional Feature:
- Macro: DUMP_HDR_EN.
- Defined: on entering each channel, before the first READ, two extra states HDR/WAIT_HDR send one header byte.
  - header value: {4'hA, channel index zero-extended to DATA_W-4 bits}.
  - same tx_start/tx_done handshake; ram_en stays low during the header.
  - each channel sends DEPTH+1 bytes.
- Undefined: no header; SELECT goes directly to READ; exactly DEPTH bytes per channel.

Test Plan:
1. ch_mask=3'b001, start_addr=0x1F0, capture_done=1; tx_done returned 4 cycles after each tx_start.
   - Expect 512 tx_start pulses.
   - ram_addr runs 0x1F0..0x1FF then 0x000..0x1EF.
   - tx_data equals ch0 RAM[addr].
   - one dump_finished and one clr_capture_done pulse; busy low the following cycle.
2. ch_mask=3'b101.
   - Expect 1024 bytes: ram_ch_sel=0 for the first 512, then 2.
   - channel 1 is never read; tx_start first appears in the 4th cycle after the req edge.
3. dump_req with capture_done=0, then with ch_mask=0.
   - Expect a reject pulse each time; no ram_en, no tx_start, busy stays 0.
4. abort after 100 bytes of a 3'b111 dump.
   - Expect busy=0 the next cycle; no dump_finished or clr_capture_done.
   - a new dump_req restarts at start_addr on channel 0.
5. dump_req pulse at byte 50, spurious tx_done in SEND, then rst_n low mid-dump.
   - Expect no restart and no extra byte.
   - on reset, all outputs 0 immediately and state IDLE.
6. DUMP_HDR_EN defined, ch_mask=3'b010.
   - Expect first byte 0xA1 with no ram_en before it, then 512 samples (513 bytes total).
